mult_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the chunked shift-add multiplier datapath. Operand A is split into A_CHUNKS

---
 rtl/mult_seq_ctrl_if.sv | 41 ++++
 rtl/mult_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Host/datapath-facing signal bundle of the chunked multiplier sequencer.
// The host side drives the request/abort controls; the sequencer drives
// state, chunk selects and datapath strobes.
interface mult_seq_ctrl_if #(
   parameter int A_CHUNKS = 2,
   parameter int B_CHUNKS = 2
);
   localparam int N_STEPS = A_CHUNKS * B_CHUNKS;
   localparam int AIW     = (A_CHUNKS > 1) ? $clog2(A_CHUNKS) : 1;
   localparam int BIW     = (B_CHUNKS > 1) ? $clog2(B_CHUNKS) : 1;
   localparam int SW      = $clog2(A_CHUNKS + B_CHUNKS - 1) + 1;
   localparam int STW     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   logic           start;
   logic           changed;
   logic           abort;
   logic           done_ack;
   logic [2:0]     state;
   logic [STW-1:0] step;
   logic [AIW-1:0] sel_a;
   logic [BIW-1:0] sel_b;
   logic [SW-1:0]  shift_amt;
   logic           data_sel;
   logic           clk_en;
   logic           busy;
   logic           done_flag;
   logic           err_flag;
   logic           fail;

   modport master (
      output start, changed, abort, done_ack,
      input  state, step, sel_a, sel_b, shift_amt, data_sel, clk_en,
             busy, done_flag, err_flag, fail
   );

   modport slave (
      input  start, changed, abort, done_ack,
      output state, step, sel_a, sel_b, shift_amt, data_sel, clk_en,
             busy, done_flag, err_flag, fail
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the chunked shift-add multiplier. Walks every (A chunk,
// B chunk) pair, A chunk index fastest, and decodes mux selects, shift and
// datapath strobes from the registered state/step/retry. Handles the
// start/done handshake, abort, and operand-change recovery with a bounded
// number of restarts.
module mult_seq_ctrl #(
   parameter int A_CHUNKS  = 2,
   parameter int B_CHUNKS  = 2,
   parameter int AUTO_CLR  = 0,
   parameter int RETRY_MAX = 1
) (
   input logic           clk,
   input logic           rst,
   mult_seq_ctrl_if.slave bus
);
   localparam int N_STEPS = A_CHUNKS * B_CHUNKS;
   localparam int AIW     = (A_CHUNKS > 1) ? $clog2(A_CHUNKS) : 1;
   localparam int BIW     = (B_CHUNKS > 1) ? $clog2(B_CHUNKS) : 1;
   localparam int SW      = $clog2(A_CHUNKS + B_CHUNKS - 1) + 1;
   localparam int STW     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam int RW      = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      LOAD   = 3'b001,
      CALC   = 3'b010,
      FINISH = 3'b101,
      ERROR  = 3'b111
   } state_t;

   state_t         cur;
   logic [STW-1:0] step_q;
   logic [RW-1:0]  retry_q;

   logic           retry_ok;
   logic           last_step;
   logic           finish_exit;

   logic [AIW-1:0] sel_a_d;
   logic [BIW-1:0] sel_b_d;
   logic [SW-1:0]  shift_d;
   logic           data_sel_d;
   logic           clk_en_d;
   logic           busy_d;
   logic           done_d;
   logic           err_d;
   logic           fail_d;

   assign retry_ok    = (retry_q < RW'(RETRY_MAX));
   assign last_step   = (step_q == STW'(N_STEPS - 1));
   assign finish_exit = (AUTO_CLR != 0) || bus.done_ack;

   // Sequencer state, CALC step counter and restart count.
   // Priority: abort, then operand change, then the normal flow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= IDLE;
         step_q  <= '0;
         retry_q <= '0;
      end else if (bus.abort) begin
         cur     <= IDLE;
         step_q  <= '0;
         retry_q <= '0;
      end else begin
         case (cur)
            IDLE: begin
               if (bus.start) begin
                  cur     <= LOAD;
                  retry_q <= '0;
               end
            end
            LOAD: begin
               step_q <= '0;
               cur    <= bus.changed ? ERROR : CALC;
            end
            CALC: begin
               if (bus.changed) begin
                  cur    <= ERROR;
                  step_q <= '0;
               end else if (last_step) begin
                  cur    <= FINISH;
                  step_q <= '0;
               end else begin
                  step_q <= step_q + STW'(1);
               end
            end
            FINISH: begin
               if (finish_exit) begin
                  if (bus.start) begin
                     cur     <= LOAD;
                     retry_q <= '0;
                  end else begin
                     cur <= IDLE;
                  end
               end
            end
            ERROR: begin
               if (!bus.changed) begin
                  if (retry_ok) begin
                     cur     <= LOAD;
                     retry_q <= retry_q + RW'(1);
                  end else begin
                     cur <= IDLE;
                  end
               end
            end
            default: begin
               cur    <= IDLE;
               step_q <= '0;
            end
         endcase
      end
   end

   // Moore decode of selects and strobes; fail also looks at the exit
   // condition of ERROR so it is high exactly in the give-up cycle.
   always_comb begin
      sel_a_d    = '0;
      sel_b_d    = '0;
      shift_d    = '0;
      data_sel_d = 1'b1;
      clk_en_d   = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      fail_d     = 1'b0;
      case (cur)
         IDLE: begin
            data_sel_d = 1'b1;
            clk_en_d   = 1'b1;
         end
         LOAD: begin
            busy_d = 1'b1;
         end
         CALC: begin
            data_sel_d = 1'b0;
            busy_d     = 1'b1;
            sel_a_d    = AIW'(int'(step_q) % A_CHUNKS);
            sel_b_d    = BIW'(int'(step_q) / A_CHUNKS);
            shift_d    = SW'(int'(step_q) % A_CHUNKS) + SW'(int'(step_q) / A_CHUNKS);
         end
         FINISH: begin
            clk_en_d = 1'b0;
            done_d   = 1'b1;
         end
         ERROR: begin
            data_sel_d = 1'b0;
            clk_en_d   = 1'b0;
            busy_d     = 1'b1;
            err_d      = 1'b1;
            fail_d     = !bus.abort && !bus.changed && !retry_ok;
         end
         default: begin
            data_sel_d = 1'b1;
            clk_en_d   = 1'b1;
         end
      endcase
   end

   assign bus.state     = cur;
   assign bus.step      = step_q;
   assign bus.sel_a     = sel_a_d;
   assign bus.sel_b     = sel_b_d;
   assign bus.shift_amt = shift_d;
   assign bus.data_sel  = data_sel_d;
   assign bus.clk_en    = clk_en_d;
   assign bus.busy      = busy_d;
   assign bus.done_flag = done_d;
   assign bus.err_flag  = err_d;
   assign bus.fail      = fail_d;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl. Two instances (2x2 with held FINISH
// and one retry; 3x1 with auto-clear and no retry) share one stimulus
// stream. A behavioural job model predicts each cycle's outputs, pushes them
// into a per-instance queue, and a negedge monitor pops and compares.
module tb_mult_seq_ctrl;
   logic clk;
   logic rst;

   mult_seq_ctrl_if #(.A_CHUNKS(2), .B_CHUNKS(2)) bus0 ();
   mult_seq_ctrl_if #(.A_CHUNKS(3), .B_CHUNKS(1)) bus1 ();

   mult_seq_ctrl #(.A_CHUNKS(2), .B_CHUNKS(2), .AUTO_CLR(0), .RETRY_MAX(1)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   mult_seq_ctrl #(.A_CHUNKS(3), .B_CHUNKS(1), .AUTO_CLR(1), .RETRY_MAX(0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model configuration per instance
   int ac  [2] = '{2, 3};
   int bc  [2] = '{2, 1};
   int acl [2] = '{0, 1};
   int rm  [2] = '{1, 0};

   // model job phase: 0 idle, 1 load, 2 calc, 3 finish, 4 error
   int ph [2];
   int kk [2];
   int rr [2];

   logic [63:0] q0[$];
   logic [63:0] q1[$];

   int nvec = 0;
   int nerr = 0;

   function automatic logic [63:0] pack(int st, int stp, int sa, int sb, int sh,
                                        bit ds, bit ce, bit bz, bit dn, bit er, bit fl);
      return {18'd0, 8'(st), 8'(stp), 8'(sa), 8'(sb), 8'(sh), ds, ce, bz, dn, er, fl};
   endfunction

   // expected outputs for the current cycle given this cycle's inputs
   function automatic logic [63:0] predict(int i, bit c, bit a);
      int  codes [5] = '{0, 1, 2, 5, 7};
      bit  calc = (ph[i] == 2);
      int  sa   = calc ? kk[i] % ac[i] : 0;
      int  sb   = calc ? kk[i] / ac[i] : 0;
      bit  ds   = (ph[i] == 0) || (ph[i] == 1) || (ph[i] == 3);
      bit  ce   = (ph[i] <= 2);
      bit  bz   = (ph[i] == 1) || calc || (ph[i] == 4);
      bit  fl   = (ph[i] == 4) && !a && !c && (rr[i] >= rm[i]);
      return pack(codes[ph[i]], calc ? kk[i] : 0, sa, sb, sa + sb,
                  ds, ce, bz, ph[i] == 3, ph[i] == 4, fl);
   endfunction

   // advance one job model across a clock edge
   task automatic advance(int i, bit s, bit c, bit a, bit d);
      int n = ac[i] * bc[i];
      if (a) begin
         ph[i] = 0; kk[i] = 0; rr[i] = 0;
         return;
      end
      case (ph[i])
         0: if (s) begin ph[i] = 1; rr[i] = 0; end
         1: begin kk[i] = 0; ph[i] = c ? 4 : 2; end
         2: begin
            if (c) begin ph[i] = 4; kk[i] = 0; end
            else if (kk[i] == n - 1) begin ph[i] = 3; kk[i] = 0; end
            else kk[i] = kk[i] + 1;
         end
         3: if (acl[i] != 0 || d) begin
            if (s) begin ph[i] = 1; rr[i] = 0; end
            else ph[i] = 0;
         end
         default: if (!c) begin
            if (rr[i] < rm[i]) begin ph[i] = 1; rr[i] = rr[i] + 1; end
            else ph[i] = 0;
         end
      endcase
   endtask

   // one cycle of stimulus: drive just after the edge, predict, advance
   task automatic cyc(bit s, bit c, bit a, bit d, bit r = 1'b1);
      @(posedge clk);
      #1;
      rst = r;
      bus0.start = s; bus0.changed = c; bus0.abort = a; bus0.done_ack = d;
      bus1.start = s; bus1.changed = c; bus1.abort = a; bus1.done_ack = d;
      for (int i = 0; i < 2; i++) begin
         if (!r) begin
            ph[i] = 0; kk[i] = 0; rr[i] = 0;
         end
      end
      q0.push_back(predict(0, c, a));
      q1.push_back(predict(1, c, a));
      if (r) begin
         for (int i = 0; i < 2; i++) advance(i, s, c, a, d);
      end
   endtask

   task automatic quiet(int n);
      for (int j = 0; j < n; j++) cyc(0, 0, 0, 0);
   endtask

   // monitor: compare each instance's outputs against the queued prediction
   initial begin
      logic [63:0] got;
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            exp = q0.pop_front();
            got = pack(int'(bus0.state), int'(bus0.step), int'(bus0.sel_a), int'(bus0.sel_b),
                       int'(bus0.shift_amt), bus0.data_sel, bus0.clk_en, bus0.busy,
                       bus0.done_flag, bus0.err_flag, bus0.fail);
            nvec++;
            if (got !== exp) begin
               nerr++;
               $display("FAIL dut0_outputs t=%0t got=%h expected=%h", $time, got, exp);
            end
         end
         if (q1.size() > 0) begin
            exp = q1.pop_front();
            got = pack(int'(bus1.state), int'(bus1.step), int'(bus1.sel_a), int'(bus1.sel_b),
                       int'(bus1.shift_amt), bus1.data_sel, bus1.clk_en, bus1.busy,
                       bus1.done_flag, bus1.err_flag, bus1.fail);
            nvec++;
            if (got !== exp) begin
               nerr++;
               $display("FAIL dut1_outputs t=%0t got=%h expected=%h", $time, got, exp);
            end
         end
      end
   end

   // stimulus
   initial begin
      rst = 1'b0;
      bus0.start = 0; bus0.changed = 0; bus0.abort = 0; bus0.done_ack = 0;
      bus1.start = 0; bus1.changed = 0; bus1.abort = 0; bus1.done_ack = 0;
      for (int i = 0; i < 2; i++) begin ph[i] = 0; kk[i] = 0; rr[i] = 0; end

      // reset state
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      quiet(2);

      // plain job, FINISH held, changed ignored in FINISH, ack+start back-to-back
      cyc(1, 0, 0, 0);
      quiet(8);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 1);

      // change at CALC step 1 lasting 3 cycles, then retry to completion
      quiet(2);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      quiet(10);
      cyc(0, 0, 0, 1);
      quiet(2);

      // two change events in one job: second exit gives up
      cyc(1, 0, 0, 0);
      quiet(2);
      cyc(0, 1, 0, 0);
      quiet(3);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      quiet(4);

      // abort together with changed during CALC
      cyc(1, 0, 0, 0);
      quiet(2);
      cyc(0, 1, 1, 0);
      quiet(2);

      // async reset mid-CALC
      cyc(1, 0, 0, 0);
      quiet(2);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      quiet(2);

      // randomized traffic
      for (int j = 0; j < 3000; j++) begin
         cyc($urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 35,
             $urandom_range(0, 399) != 0);
      end
      quiet(2);

      @(negedge clk);
      @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         nerr++;
         $display("FAIL queue_drain left0=%0d left1=%0d expected=0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
